// File: rtl/controle_minigames_if.sv
// Minigame sequencer bus: buttons/status into the sequencer,
// mux select, pulses and state code out of it.
interface controle_minigames_if;
  logic       iniciar;
  logic       confirmar;
  logic       sair;
  logic [1:0] selecao;
  logic       pronto;
  logic [1:0] minigame;
  logic       reset_jogo;
  logic [2:0] iniciar_jogo;
  logic [3:0] estado_inicial;
  logic [3:0] jogos_concluidos;

  modport master (
    output iniciar, confirmar, sair, selecao, pronto,
    input  minigame, reset_jogo, iniciar_jogo,
    input  estado_inicial, jogos_concluidos
  );

  modport slave (
    input  iniciar, confirmar, sair, selecao, pronto,
    output minigame, reset_jogo, iniciar_jogo,
    output estado_inicial, jogos_concluidos
  );
endinterface

// File: rtl/controle_minigames.sv
// Minigame subsystem sequencer: menu, game select, start/reset pulses.
// Define MODO_ALEATORIO_EN for LFSR random pick on selecao=11.
module controle_minigames #(
  parameter int unsigned TEMPO_RESULTADO = 5000
) (
  input  logic                 clock,
  input  logic                 reset,
  controle_minigames_if.slave  bus
);

  localparam int CW = $clog2(TEMPO_RESULTADO + 1);

  typedef enum logic [3:0] {
    INICIAL = 4'd0,
    MENU    = 4'd1,
    PREPARA = 4'd2,
    INICIA  = 4'd3,
    JOGANDO = 4'd4,
    FIM     = 4'd5,
    ABORTA  = 4'd6
  } estado_t;

  estado_t est_q, est_d;
  logic [1:0]    sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    jogos_q, jogos_d;
  logic [1:0]    mg_q, mg_d;
  logic          rj_q, rj_d;
  logic [2:0]    ij_q, ij_d;

  logic ini_q, conf_q, sair_q, arm_q;
  logic ini_ed, conf_ed, sair_ed;

  // arm_q masks the first cycle after reset so held buttons never edge
  assign ini_ed  = bus.iniciar   & ~ini_q  & arm_q;
  assign conf_ed = bus.confirmar & ~conf_q & arm_q;
  assign sair_ed = bus.sair      & ~sair_q & arm_q;

`ifdef MODO_ALEATORIO_EN
  logic [7:0] lfsr_q;
  logic [1:0] rnd;

  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr_q <= 8'h01;
    end else begin
      lfsr_q <= {lfsr_q[6:0],
                 lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign rnd = (lfsr_q[1:0] == 2'b11) ? 2'b00 : lfsr_q[1:0];
`endif

  always_comb begin
    est_d   = est_q;
    sel_d   = sel_q;
    cnt_d   = '0;
    jogos_d = jogos_q;
    unique case (est_q)
      INICIAL: begin
        if (ini_ed) est_d = MENU;
      end
      MENU: begin
        if (conf_ed) begin
          if (bus.selecao != 2'b11) begin
            sel_d = bus.selecao;
            est_d = PREPARA;
          end
`ifdef MODO_ALEATORIO_EN
          else begin
            sel_d = rnd;
            est_d = PREPARA;
          end
`endif
        end
      end
      PREPARA: est_d = INICIA;
      INICIA:  est_d = JOGANDO;
      JOGANDO: begin
        if (bus.pronto) begin
          est_d = FIM;
          if (jogos_q != 4'hF) jogos_d = jogos_q + 4'd1;
        end else if (sair_ed) begin
          est_d = ABORTA;
        end
      end
      FIM: begin
        if (conf_ed || cnt_q == CW'(TEMPO_RESULTADO - 1))
          est_d = MENU;
        else
          cnt_d = cnt_q + CW'(1);
      end
      ABORTA:  est_d = MENU;
      default: est_d = INICIAL;
    endcase

    // outputs decoded from the next state, then registered
    mg_d = 2'b11;
    rj_d = 1'b0;
    ij_d = 3'b000;
    unique case (est_d)
      PREPARA: begin
        mg_d = sel_d;
        rj_d = 1'b1;
      end
      INICIA: begin
        mg_d = sel_d;
        ij_d = 3'b001 << sel_d;
      end
      JOGANDO, FIM: mg_d = sel_d;
      ABORTA: begin
        mg_d = sel_d;
        rj_d = 1'b1;
      end
      default: mg_d = 2'b11;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      est_q   <= INICIAL;
      sel_q   <= 2'b00;
      cnt_q   <= '0;
      jogos_q <= 4'd0;
      mg_q    <= 2'b11;
      rj_q    <= 1'b0;
      ij_q    <= 3'b000;
      ini_q   <= 1'b0;
      conf_q  <= 1'b0;
      sair_q  <= 1'b0;
      arm_q   <= 1'b0;
    end else begin
      est_q   <= est_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      jogos_q <= jogos_d;
      mg_q    <= mg_d;
      rj_q    <= rj_d;
      ij_q    <= ij_d;
      ini_q   <= bus.iniciar;
      conf_q  <= bus.confirmar;
      sair_q  <= bus.sair;
      arm_q   <= 1'b1;
    end
  end

  assign bus.minigame         = mg_q;
  assign bus.reset_jogo       = rj_q;
  assign bus.iniciar_jogo     = ij_q;
  assign bus.estado_inicial   = est_q;
  assign bus.jogos_concluidos = jogos_q;

endmodule

// File: tb/tb_controle_minigames.sv
// Directed bench for controle_minigames with TEMPO_RESULTADO=4.
// Define MODO_ALEATORIO_EN to exercise the random-pick path.
module tb_controle_minigames;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errs   = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  controle_minigames_if bus();

  controle_minigames #(.TEMPO_RESULTADO(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

`ifdef MODO_ALEATORIO_EN
  logic [7:0] lfsr_m;
  always @(posedge clock) begin
    if (reset) lfsr_m <= 8'h01;
    else lfsr_m <= {lfsr_m[6:0],
                    lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end
`endif

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clr_inputs;
    bus.iniciar   = 1'b0;
    bus.confirmar = 1'b0;
    bus.sair      = 1'b0;
    bus.selecao   = 2'b00;
    bus.pronto    = 1'b0;
  endtask

  task automatic do_reset;
    clr_inputs();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(2);
  endtask

  task automatic go_menu;
    logic [3:0] got;
    bus.iniciar = 1'b1;
    cyc();
    got = bus.estado_inicial;
    checks++;
    if (got !== 4'd1) begin
      errs++;
      $display("FAIL to_menu got=%0d want=1", got);
    end
    bus.iniciar = 1'b0;
    cyc();
  endtask

  task automatic start_game(input logic [1:0] s);
    logic [9:0] got, exp;
    bus.selecao   = s;
    bus.confirmar = 1'b1;
    cyc();
    got = {bus.estado_inicial, bus.reset_jogo, bus.minigame, bus.iniciar_jogo};
    exp = {4'd2, 1'b1, s, 3'b000};
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL prepara got=%h want=%h", got, exp);
    end
    bus.confirmar = 1'b0;
    cyc();
    got = {bus.estado_inicial, bus.reset_jogo, bus.minigame, bus.iniciar_jogo};
    exp = {4'd3, 1'b0, s, 3'(3'b001 << s)};
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL inicia got=%h want=%h", got, exp);
    end
    cyc();
    got = {bus.estado_inicial, bus.reset_jogo, bus.minigame, bus.iniciar_jogo};
    exp = {4'd4, 1'b0, s, 3'b000};
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL jogando got=%h want=%h", got, exp);
    end
  endtask

  task automatic test_reset;
    logic [13:0] got;
    clr_inputs();
    bus.iniciar   = 1'b1;
    bus.confirmar = 1'b1;
    reset = 1'b1;
    cyc(2);
    got = {bus.estado_inicial, bus.minigame, bus.reset_jogo,
           bus.iniciar_jogo, bus.jogos_concluidos};
    checks++;
    if (got !== {4'd0, 2'b11, 1'b0, 3'b000, 4'd0}) begin
      errs++;
      $display("FAIL reset_vals got=%h want=%h", got,
               {4'd0, 2'b11, 1'b0, 3'b000, 4'd0});
    end
    reset = 1'b0;
    cyc(3);
    checks++;
    if (bus.estado_inicial !== 4'd0) begin
      errs++;
      $display("FAIL held_press got=%0d want=0", bus.estado_inicial);
    end
    clr_inputs();
    cyc();
  endtask

  task automatic test_basic;
    logic [9:0] got;
    do_reset();
    go_menu();
    start_game(2'b01);
    bus.pronto = 1'b1;
    cyc();
    got = {bus.estado_inicial, bus.minigame, bus.jogos_concluidos};
    checks++;
    if (got !== {4'd5, 2'b01, 4'd1}) begin
      errs++;
      $display("FAIL fim_entry got=%h want=%h", got, {4'd5, 2'b01, 4'd1});
    end
    bus.pronto = 1'b0;
    for (int i = 1; i < 4; i++) begin
      cyc();
      checks++;
      if (bus.estado_inicial !== 4'd5) begin
        errs++;
        $display("FAIL fim_hold%0d got=%0d want=5", i, bus.estado_inicial);
      end
    end
    cyc();
    got = {bus.estado_inicial, bus.minigame, bus.jogos_concluidos};
    checks++;
    if (got !== {4'd1, 2'b11, 4'd1}) begin
      errs++;
      $display("FAIL fim_timeout got=%h want=%h", got, {4'd1, 2'b11, 4'd1});
    end
  endtask

  task automatic test_simultaneous;
    logic [7:0] got;
    start_game(2'b10);
    bus.sair   = 1'b1;
    bus.pronto = 1'b1;
    cyc();
    got = {bus.estado_inicial, bus.jogos_concluidos};
    checks++;
    if (got !== {4'd5, 4'd2}) begin
      errs++;
      $display("FAIL pronto_wins got=%h want=%h", got, {4'd5, 4'd2});
    end
    bus.sair      = 1'b0;
    bus.pronto    = 1'b0;
    bus.confirmar = 1'b1;
    cyc();
    checks++;
    if (bus.estado_inicial !== 4'd1) begin
      errs++;
      $display("FAIL fim_confirm got=%0d want=1", bus.estado_inicial);
    end
    bus.confirmar = 1'b0;
    cyc();
  endtask

  task automatic test_abort;
    logic [10:0] got;
    start_game(2'b00);
    bus.sair = 1'b1;
    cyc();
    got = {4'd0, bus.estado_inicial, bus.reset_jogo, bus.minigame};
    checks++;
    if (got !== {4'd0, 4'd6, 1'b1, 2'b00}) begin
      errs++;
      $display("FAIL aborta got=%h want=%h", got, {4'd0, 4'd6, 1'b1, 2'b00});
    end
    bus.sair = 1'b0;
    cyc();
    got = {bus.estado_inicial, bus.reset_jogo, bus.minigame,
           bus.jogos_concluidos};
    checks++;
    if (got !== {4'd1, 1'b0, 2'b11, 4'd2}) begin
      errs++;
      $display("FAIL abort_menu got=%h want=%h", got,
               {4'd1, 1'b0, 2'b11, 4'd2});
    end
  endtask

  task automatic test_sel11;
    logic [7:0] got;
`ifdef MODO_ALEATORIO_EN
    logic [1:0] e;
    e = (lfsr_m[1:0] == 2'b11) ? 2'b00 : lfsr_m[1:0];
`endif
    bus.selecao   = 2'b11;
    bus.confirmar = 1'b1;
    cyc();
`ifndef MODO_ALEATORIO_EN
    for (int i = 0; i < 2; i++) begin
      got = {bus.estado_inicial, bus.reset_jogo, bus.iniciar_jogo};
      checks++;
      if (got !== {4'd1, 1'b0, 3'b000}) begin
        errs++;
        $display("FAIL sel11_%0d got=%h want=%h", i, got,
                 {4'd1, 1'b0, 3'b000});
      end
      bus.confirmar = 1'b0;
      cyc();
    end
`else
    got = {2'b00, bus.estado_inicial, bus.minigame};
    checks++;
    if (got !== {2'b00, 4'd2, e}) begin
      errs++;
      $display("FAIL rnd_sel got=%h want=%h", got, {2'b00, 4'd2, e});
    end
    bus.confirmar = 1'b0;
    cyc();
    got = {5'd0, bus.iniciar_jogo};
    checks++;
    if (got !== {5'd0, 3'(3'b001 << e)}) begin
      errs++;
      $display("FAIL rnd_start got=%h want=%h", got,
               {5'd0, 3'(3'b001 << e)});
    end
    cyc();
    bus.sair = 1'b1;
    cyc();
    bus.sair = 1'b0;
    cyc();
`endif
  endtask

  task automatic test_fim_confirm;
    start_game(2'b01);
    bus.pronto = 1'b1;
    cyc();
    bus.pronto    = 1'b0;
    bus.confirmar = 1'b1;
    cyc();
    checks++;
    if (bus.estado_inicial !== 4'd1) begin
      errs++;
      $display("FAIL fim_cycle1 got=%0d want=1", bus.estado_inicial);
    end
    bus.confirmar = 1'b0;
    cyc();
  endtask

  task automatic test_saturate;
    logic [3:0] exp;
    do_reset();
    go_menu();
    for (int i = 0; i < 16; i++) begin
      start_game(2'(i % 3));
      bus.pronto = 1'b1;
      cyc();
      bus.pronto = 1'b0;
      exp = (i < 15) ? 4'(i + 1) : 4'd15;
      checks++;
      if (bus.jogos_concluidos !== exp) begin
        errs++;
        $display("FAIL sat_%0d got=%0d want=%0d", i,
                 bus.jogos_concluidos, exp);
      end
      bus.confirmar = 1'b1;
      cyc();
      bus.confirmar = 1'b0;
      cyc();
    end
  endtask

  task automatic test_reset_mid;
    logic [13:0] got;
    start_game(2'b01);
    reset = 1'b1;
    cyc();
    got = {bus.estado_inicial, bus.minigame, bus.reset_jogo,
           bus.iniciar_jogo, bus.jogos_concluidos};
    checks++;
    if (got !== {4'd0, 2'b11, 1'b0, 3'b000, 4'd0}) begin
      errs++;
      $display("FAIL reset_mid got=%h want=%h", got,
               {4'd0, 2'b11, 1'b0, 3'b000, 4'd0});
    end
    reset = 1'b0;
    cyc(2);
  endtask

  initial begin
    clr_inputs();
    test_reset();
    test_basic();
    test_simultaneous();
    test_abort();
    test_sel11();
    test_fim_confirm();
    test_saturate();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
